// File: rtl/reg_pipe_chain_if.sv
// reg_pipe_chain_if: control, data and status bundle of the tapped delay line
interface reg_pipe_chain_if #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4
);
   localparam int TAP_W = $clog2(DEPTH + 1);
   logic             ce_i;
   logic             flush_i;
   logic [WIDTH-1:0] din_i;
   logic             din_vld_i;
   logic [TAP_W-1:0] tap_i;
   logic [WIDTH-1:0] dout_o;
   logic             dout_vld_o;
   logic [TAP_W-1:0] count_o;
   logic             empty_o;
   logic             full_o;
   modport master (
      output ce_i, flush_i, din_i, din_vld_i, tap_i,
      input  dout_o, dout_vld_o, count_o, empty_o, full_o
   );
   modport slave (
      input  ce_i, flush_i, din_i, din_vld_i, tap_i,
      output dout_o, dout_vld_o, count_o, empty_o, full_o
   );
endinterface

// File: rtl/reg_pipe_chain.sv
// reg_pipe_chain: DEPTH-stage delay line with runtime latency tap, valid tracking and flush
module reg_pipe_chain #(
   parameter int               WIDTH       = 18,
   parameter int               DEPTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter bit               CLR_DATA    = 1'b1
) (
   input logic             clk,
   input logic             rst_n,
   reg_pipe_chain_if.slave bus
);
   localparam int               TAP_W   = $clog2(DEPTH + 1);
   localparam logic [TAP_W-1:0] DEPTH_T = TAP_W'(DEPTH);
   logic [WIDTH-1:0] data_q  [1:DEPTH];
   logic [WIDTH-1:0] data_d  [1:DEPTH];
   logic [WIDTH-1:0] stage_c [0:DEPTH];
   logic [DEPTH:1]   vld_q, vld_d;
   logic [DEPTH:0]   vld_c;
   logic [TAP_W-1:0] count_q, count_d, tap_c;
   // next state: flush beats advance, advance shifts every stage, otherwise hold
   always_comb begin
      data_d  = data_q;
      vld_d   = vld_q;
      count_d = count_q;
      if (bus.flush_i) begin
         vld_d   = '0;
         count_d = '0;
         if (CLR_DATA) data_d = '{default: RESET_VALUE};
      end else if (bus.ce_i) begin
         data_d[1] = bus.din_i;
         vld_d[1]  = bus.din_vld_i;
         for (int k = 2; k <= DEPTH; k++) begin
            data_d[k] = data_q[k-1];
            vld_d[k]  = vld_q[k-1];
         end
         count_d = count_q + TAP_W'(bus.din_vld_i) - TAP_W'(vld_q[DEPTH]);
      end
   end
   // stage registers and occupancy counter, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '{default: RESET_VALUE};
         vld_q   <= '0;
         count_q <= '0;
      end else begin
         data_q  <= data_d;
         vld_q   <= vld_d;
         count_q <= count_d;
      end
   end
   // tap mux: index 0 is the live input, taps beyond the last stage clamp to it
   always_comb begin
      stage_c[0] = bus.din_i;
      for (int k = 1; k <= DEPTH; k++) stage_c[k] = data_q[k];
      vld_c = {vld_q, bus.din_vld_i};
      tap_c = (bus.tap_i > DEPTH_T) ? DEPTH_T : bus.tap_i;
   end
   assign bus.dout_o     = stage_c[tap_c];
   assign bus.dout_vld_o = vld_c[tap_c];
   assign bus.count_o    = count_q;
   assign bus.empty_o    = count_q == '0;
   assign bus.full_o     = count_q == DEPTH_T;
   a_count_matches_valids: assert property (@(posedge clk) disable iff (!rst_n)
      count_q == TAP_W'($countones(vld_q)));
endmodule

// File: tb/tb_reg_pipe_chain.sv
// tb_reg_pipe_chain: randomized scoreboard bench with a history-queue reference model
`timescale 1ns/1ps
module tb_reg_pipe_chain;
   localparam int             W  = 18;
   localparam int             D  = 4;
   localparam int             TW = $clog2(D + 1);
   localparam logic [W-1:0]   RV = 18'h2A5A5;
   typedef struct packed {logic [W-1:0] d; logic v;} ent_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   bit   sb_en = 1'b0;
   logic [W-1:0] sb[$];
   ent_t hist[$];
   int   pat[5] = '{1, 0, 1, 1, 0};
   int   bub[8] = '{1, 1, 2, 3, 2, 2, 1, 0};
   reg_pipe_chain_if #(.WIDTH(W), .DEPTH(D)) bus ();
   reg_pipe_chain #(.WIDTH(W), .DEPTH(D), .RESET_VALUE(RV), .CLR_DATA(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   always #10 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask
   // reference: newest-first list of the last D accepted words
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist.delete();
         repeat (D) hist.push_back('{d: RV, v: 1'b0});
      end else if (bus.flush_i) begin
         foreach (hist[i]) hist[i] = '{d: RV, v: 1'b0};
      end else if (bus.ce_i) begin
         hist.push_front('{d: bus.din_i, v: bus.din_vld_i});
         void'(hist.pop_back());
      end
   end
   function automatic int tsel();
      return (int'(bus.tap_i) > D) ? D : int'(bus.tap_i);
   endfunction
   function automatic int nvalid();
      int c = 0;
      foreach (hist[i]) c += int'(hist[i].v);
      return c;
   endfunction
   // every cycle: all outputs against the reference
   always @(negedge clk) begin
      if (rst_n && hist.size() == D) begin
         int t, c;
         t = tsel();
         c = nvalid();
         chk("dout", 32'(bus.dout_o), (t == 0) ? 32'(bus.din_i) : 32'(hist[t-1].d));
         chk("dout_vld", 32'(bus.dout_vld_o), (t == 0) ? 32'(bus.din_vld_i) : 32'(hist[t-1].v));
         chk("count", 32'(bus.count_o), 32'(c));
         chk("empty", 32'(bus.empty_o), 32'(c == 0));
         chk("full", 32'(bus.full_o), 32'(c == D));
      end
   end
   // monitor: a valid word at the tap is consumed when the pipe advances
   always @(negedge clk) begin
      if (rst_n && sb_en && bus.dout_vld_o && bus.ce_i && !bus.flush_i) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_extra_word: got %0h expected no word", bus.dout_o);
         end else begin
            chk("sb_word", 32'(bus.dout_o), 32'(sb.pop_front()));
         end
      end
   end
   task automatic step(input logic c, input logic f, input logic [W-1:0] d, input logic v);
      bus.ce_i      = c;
      bus.flush_i   = f;
      bus.din_i     = d;
      bus.din_vld_i = v;
      if (sb_en && c && !f && v) sb.push_back(d);
      @(posedge clk);
      #1;
      if (f) sb.delete();
   endtask
   initial begin
      bus.ce_i      = 1'b0;
      bus.flush_i   = 1'b0;
      bus.din_i     = '0;
      bus.din_vld_i = 1'b0;
      bus.tap_i     = TW'(2);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_count", 32'(bus.count_o), 0);
      chk("rst_empty", 32'(bus.empty_o), 1);
      chk("rst_full", 32'(bus.full_o), 0);
      chk("rst_vld", 32'(bus.dout_vld_o), 0);
      chk("rst_dout", 32'(bus.dout_o), 32'(RV));
      rst_n = 1'b1;
      bus.tap_i = TW'(3);
      step(1, 0, W'(1), 1);
      step(1, 0, W'(2), 1);
      chk("lat_early_vld", 32'(bus.dout_vld_o), 0);
      step(1, 0, W'(3), 1);
      chk("lat3_dout", 32'(bus.dout_o), 1);
      chk("lat3_vld", 32'(bus.dout_vld_o), 1);
      bus.ce_i = 1'b0;
      bus.tap_i = '0;
      bus.din_i = W'(55);
      #1;
      chk("tap0_dout", 32'(bus.dout_o), 55);
      chk("tap0_vld", 32'(bus.dout_vld_o), 1);
      step(0, 1, '0, 0);
      bus.tap_i = TW'(4);
      sb_en = 1'b1;
      for (int i = 0; i < 4; i++) step(1, 0, W'(10 + i), 1);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, W'($urandom), 1'($urandom));
         chk("stall_count", 32'(bus.count_o), 4);
         chk("stall_full", 32'(bus.full_o), 1);
         chk("stall_dout", 32'(bus.dout_o), 10);
      end
      for (int i = 0; i < 4; i++) step(1, 0, '0, 0);
      chk("stall_drained", 32'(sb.size()), 0);
      chk("stall_empty", 32'(bus.empty_o), 1);
      sb_en = 1'b0;
      bus.tap_i = TW'(3);
      for (int i = 0; i < 3; i++) step(1, 0, W'(20 + i), 1);
      chk("pre_flush_count", 32'(bus.count_o), 3);
      step(1, 1, W'(99), 1);
      bus.ce_i      = 1'b0;
      bus.flush_i   = 1'b0;
      bus.din_vld_i = 1'b0;
      chk("flush_count", 32'(bus.count_o), 0);
      chk("flush_empty", 32'(bus.empty_o), 1);
      for (int t = 0; t <= D; t++) begin
         bus.tap_i = TW'(t);
         #1;
         chk("flush_vld", 32'(bus.dout_vld_o), 0);
         if (t > 0) chk("flush_data", 32'(bus.dout_o), 32'(RV));
      end
      bus.tap_i = TW'(4);
      for (int i = 0; i < 8; i++) begin
         step(1, 0, W'(40 + i), (i < 5) ? 1'(pat[i]) : 1'b0);
         chk("bubble_count", 32'(bus.count_o), 32'(bub[i]));
      end
      bus.tap_i = TW'(7);
      for (int i = 0; i < 4; i++) step(1, 0, W'(30 + i), 1);
      chk("clamp7_dout", 32'(bus.dout_o), 30);
      chk("clamp7_vld", 32'(bus.dout_vld_o), 1);
      bus.ce_i = 1'b0;
      bus.tap_i = TW'(4);
      #1;
      chk("tap4_dout", 32'(bus.dout_o), 30);
      bus.tap_i = TW'(1);
      #1;
      chk("tap1_dout", 32'(bus.dout_o), 33);
      chk("tap_sw_count", 32'(bus.count_o), 4);
      step(1, 0, W'(34), 1);
      chk("tap1_next", 32'(bus.dout_o), 34);
      for (int p = 0; p < 10; p++) begin
         step(0, 1, '0, 0);
         bus.tap_i = TW'($urandom_range(0, 7));
         sb_en = 1'b1;
         for (int i = 0; i < 80; i++)
            step(($urandom % 4) != 0, ($urandom % 25) == 0, W'($urandom), ($urandom % 3) != 0);
         for (int i = 0; i <= D; i++) step(1, 0, W'($urandom), 0);
         chk("sb_drained", 32'(sb.size()), 0);
         sb_en = 1'b0;
      end
      bus.tap_i = TW'(2);
      for (int i = 0; i < 4; i++) step(1, 0, W'(60 + i), 1);
      chk("pre_rst_full", 32'(bus.full_o), 1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_vld", 32'(bus.dout_vld_o), 0);
      chk("async_rst_count", 32'(bus.count_o), 0);
      chk("async_rst_empty", 32'(bus.empty_o), 1);
      chk("async_rst_dout", 32'(bus.dout_o), 32'(RV));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1, 0, W'(77), 1);
      chk("post_rst_early", 32'(bus.dout_vld_o), 0);
      step(1, 0, W'(78), 1);
      chk("post_rst_vld", 32'(bus.dout_vld_o), 1);
      chk("post_rst_dout", 32'(bus.dout_o), 77);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
